// File: rtl/mx_block_quant_ctrl.sv
// Buffers k signed fixed-point elements, derives one shared right-shift from the largest magnitude
// bit position, then emits each element shifted with RNE rounding and saturation.
module mx_block_quant_ctrl #(
  parameter int width_i     = 16,
  parameter int width_o     = 8,
  parameter int k           = 32,
  parameter int width_shift = $clog2(width_i + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [width_i-1:0]     i_num,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [width_o-1:0]     o_num,
  output logic [width_shift-1:0] o_scale,
  output logic                   o_first,
  output logic                   o_last,
  output logic                   o_ofl,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int CW = (k > 1) ? $clog2(k) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(k - 1);
  localparam logic [width_shift-1:0] L_OFF = width_shift'(width_o - 1);
  localparam logic signed [width_i:0] L_MAX = {{(width_i - width_o + 2){1'b0}}, {(width_o - 1){1'b1}}};
  localparam logic signed [width_i:0] L_MIN = {{(width_i - width_o + 2){1'b1}}, {(width_o - 1){1'b0}}};

  typedef enum logic [1:0] {S_FILL, S_CALC, S_EMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [width_i-1:0]     r_buf [k];
  logic [CW-1:0]          r_cnt;
  // Running max stored as p+1 so that the cleared value 0 stands for p=-1.
  logic [width_shift-1:0] r_pmax;
  logic [width_shift-1:0] r_scale;
  logic [width_o-1:0]     r_num;
  logic                   r_first, r_last, r_ofl, r_valid;

  logic                        w_in_beat, w_out_beat;
  logic [width_shift-1:0]      w_p1, w_sh, w_shu;
  logic [CW-1:0]               w_idx;
  logic signed [width_i-1:0]   w_v, w_y;
  logic signed [width_i:0]     w_r;
  logic                        w_g, w_rs, w_inc;
  logic [width_o-1:0]          w_q;
  logic                        w_ofl;

  assign w_in_beat  = i_valid && o_ready;
  assign w_out_beat = r_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_in_beat && r_cnt == L_LAST) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_EMIT;
      S_EMIT:  if (w_out_beat && r_cnt == L_LAST) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_FILL) && !i_rst;
  end

  always_comb begin
    w_p1 = '0;
    for (int b = 0; b < width_i - 1; b++) begin
      if (i_num[b] ^ i_num[width_i-1]) w_p1 = width_shift'(b + 1);
    end
  end

  assign w_sh  = (r_pmax > L_OFF) ? (r_pmax - L_OFF) : '0;
  assign w_shu = (r_state == S_CALC) ? w_sh : r_scale;
  assign w_idx = (r_state == S_CALC || r_cnt == L_LAST) ? '0 : r_cnt + 1'b1;
  assign w_v   = r_buf[w_idx];
  assign w_y   = w_v >>> w_shu;

  always_comb begin
    w_g  = 1'b0;
    w_rs = 1'b0;
    for (int b = 0; b < width_i; b++) begin
      if (b + 1 == int'(w_shu))     w_g  = w_v[b];
      else if (b + 1 < int'(w_shu)) w_rs = w_rs | w_v[b];
    end
    w_inc = w_g && (w_y[0] || w_rs);
    w_r   = {w_y[width_i-1], w_y} + {{width_i{1'b0}}, w_inc};
    w_ofl = 1'b0;
    w_q   = w_r[width_o-1:0];
    if (w_r > L_MAX) begin
      w_q   = {1'b0, {(width_o - 1){1'b1}}};
      w_ofl = 1'b1;
    end else if (w_r < L_MIN) begin
      w_q   = {1'b1, {(width_o - 1){1'b0}}};
      w_ofl = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_pmax  <= '0;
      r_scale <= '0;
      r_num   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_ofl   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: if (w_in_beat) begin
          r_buf[r_cnt] <= i_num;
          r_cnt        <= (r_cnt == L_LAST) ? '0 : r_cnt + 1'b1;
          if (w_p1 > r_pmax) r_pmax <= w_p1;
        end
        S_CALC: begin
          r_scale <= w_sh;
          r_num   <= w_q;
          r_ofl   <= w_ofl;
          r_first <= 1'b1;
          r_last  <= (w_idx == L_LAST);
          r_valid <= 1'b1;
        end
        S_EMIT: if (w_out_beat) begin
          if (r_cnt == L_LAST) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_pmax  <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_num   <= w_q;
            r_ofl   <= w_ofl;
            r_first <= 1'b0;
            r_last  <= (w_idx == L_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_num   = r_num;
  assign o_scale = r_scale;
  assign o_first = r_first;
  assign o_last  = r_last;
  assign o_ofl   = r_ofl;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_mx_block_quant_ctrl.sv
// Bench for mx_block_quant_ctrl with k=4, 16-bit in, 8-bit out; expected beats come from an
// integer model of the shared-scale, RNE and saturation rules.
module tb_mx_block_quant_ctrl;
  localparam int WI = 16;
  localparam int WO = 8;
  localparam int K  = 4;
  localparam int WS = $clog2(WI + 1);

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic signed [WI-1:0] i_num;
  logic                 i_valid;
  logic                 o_ready;
  logic [WO-1:0]        o_num;
  logic [WS-1:0]        o_scale;
  logic                 o_first, o_last, o_ofl, o_valid;
  logic                 i_ready;

  int n_chk  = 0;
  int n_fail = 0;

  mx_block_quant_ctrl #(.width_i(WI), .width_o(WO), .k(K)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_num(i_num), .i_valid(i_valid), .o_ready(o_ready),
    .o_num(o_num), .o_scale(o_scale), .o_first(o_first), .o_last(o_last), .o_ofl(o_ofl),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic int p_of(input int v);
    int m;
    int p;
    m = (v < 0) ? ~v : v;
    p = -1;
    for (int b = 0; b < 31; b++) if (m >= (1 << b)) p = b;
    return p;
  endfunction

  function automatic void quant(input int v, input int sh, output int q, output bit ofl);
    int y;
    int rem;
    int half;
    y = v >>> sh;
    if (sh > 0) begin
      rem  = v - (y <<< sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (y % 2 != 0))) y++;
    end
    ofl = 1'b0;
    if (y > (1 << (WO - 1)) - 1) begin y = (1 << (WO - 1)) - 1; ofl = 1'b1; end
    else if (y < -(1 << (WO - 1))) begin y = -(1 << (WO - 1)); ofl = 1'b1; end
    q = y;
  endfunction

  // Feeds one block (with random idle gaps), then drains it, stalling stall_len cycles on stall_beat.
  task automatic run_block(input string nm, input int v[K], input int stall_beat, input int stall_len);
    int pmax;
    int sh;
    int eq[K];
    bit eo[K];
    int j;
    int guard;
    int stall;
    logic [WO-1:0] exp_q;
    pmax = -1;
    for (int i = 0; i < K; i++) if (p_of(v[i]) > pmax) pmax = p_of(v[i]);
    sh = (pmax - (WO - 2) > 0) ? pmax - (WO - 2) : 0;
    for (int i = 0; i < K; i++) quant(v[i], sh, eq[i], eo[i]);

    for (int i = 0; i < K; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        i_num   = 16'($urandom);
        @(negedge i_clk);
        n_chk++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL %s gap_ready got %b exp 1", nm, o_ready); end
        @(posedge i_clk); #1;
      end
      i_valid = 1'b1;
      i_num   = 16'(v[i]);
      @(negedge i_clk);
      n_chk++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL %s fill_hs got rdy=%b vld=%b exp rdy=1 vld=0", nm, o_ready, o_valid);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_num   = 16'($urandom);
    @(negedge i_clk);
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s calc_cycle got vld=%b rdy=%b exp 0 0", nm, o_valid, o_ready);
    end
    @(posedge i_clk); #1;

    j = 0; guard = 0; stall = stall_len;
    while (j < K && guard < 200) begin
      i_ready = (j == stall_beat && stall > 0) ? 1'b0 : 1'b1;
      @(negedge i_clk);
      exp_q = eq[j][WO-1:0];
      n_chk++;
      if (o_valid !== 1'b1 || o_num !== exp_q || o_scale !== WS'(sh) || o_ofl !== eo[j] ||
          o_first !== (j == 0) || o_last !== (j == K - 1)) begin
        n_fail++;
        $display("FAIL %s beat%0d got vld=%b num=%0d sc=%0d ofl=%b f=%b l=%b exp vld=1 num=%0d sc=%0d ofl=%b f=%b l=%b",
                 nm, j, o_valid, $signed(o_num), o_scale, o_ofl, o_first, o_last,
                 eq[j], sh, eo[j], (j == 0), (j == K - 1));
      end
      if (!i_ready) begin
        n_chk++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL %s stall_ready got %b exp 0", nm, o_ready); end
      end
      @(posedge i_clk); #1;
      if (i_ready) j++; else stall--;
      guard++;
    end
    if (guard >= 200) begin n_fail++; $display("FAIL %s drain_timeout got %0d beats exp %0d", nm, j, K); end
    i_ready = $urandom_range(0, 1);
    @(negedge i_clk);
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s after_last got vld=%b rdy=%b exp vld=0 rdy=1", nm, o_valid, o_ready);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_num = '0;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    n_chk++;
    if (o_valid !== 1'b0 || o_num !== '0 || o_scale !== '0 || o_first !== 1'b0 ||
        o_last !== 1'b0 || o_ofl !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got vld=%b num=%0d sc=%0d f=%b l=%b ofl=%b rdy=%b exp all 0",
               o_valid, o_num, o_scale, o_first, o_last, o_ofl, o_ready);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_directed;
    int blk[K];
    blk = '{5, -3, 100, 0};         run_block("plan1", blk, -1, 0);
    blk = '{254, 1, 3, -3};         run_block("plan2", blk, -1, 0);
    blk = '{255, -5, 6, 7};         run_block("plan3", blk, -1, 0);
    blk = '{-32768, 1024, -1, 0};   run_block("plan4", blk, -1, 0);
    blk = '{0, 0, 0, 0};            run_block("zeros", blk, -1, 0);
    blk = '{-1, -1, -1, -1};        run_block("ones", blk, -1, 0);
    blk = '{32767, -32768, 128, -129}; run_block("extremes", blk, -1, 0);
  endtask

  task automatic test_backpressure;
    int blk[K];
    blk = '{5, -3, 100, 0};
    run_block("bp", blk, 2, 5);
  endtask

  task automatic test_random;
    int blk[K];
    int r;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < K; i++) begin
        r = $urandom;
        blk[i] = r >>> $urandom_range(16, 31);
      end
      run_block("rand", blk, $urandom_range(0, K - 1), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_abort;
    int blk[K];
    int guard;
    i_valid = 1'b1; i_num = 16'sd30000;
    @(posedge i_clk); #1;
    i_num = -16'sd20000;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_fill got rdy=%b vld=%b exp 0 0", o_ready, o_valid);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    blk = '{1, 2, 3, 4};
    run_block("after_rst_fill", blk, -1, 0);

    for (int i = 0; i < K; i++) begin
      i_valid = 1'b1; i_num = 16'(20000 - 9000 * i);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    guard = 0;
    while (o_valid !== 1'b1 && guard < 10) begin @(posedge i_clk); #1; guard++; end
    n_chk++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL emit_timeout got vld=%b exp 1", o_valid); end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_rst = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_emit_rdy got %b exp 0", o_ready); end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_chk++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_emit got vld=%b rdy=%b exp 0 0", o_valid, o_ready);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    run_block("after_rst_emit", blk, -1, 0);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
